// File: rtl/sprite_renderer.sv
// Sprite renderer: on each frame-start, erases the previous sprite box with the
// background colour, then draws the new sprite from a registered ROM onto the LCD.
module sprite_renderer #(
    parameter int          SPR_BITS    = 5,
    parameter int          LCD_W       = 240,
    parameter int          LCD_H       = 320,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter logic [15:0] BG_COLOUR   = 16'hFFFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    frameStart,
    input  logic [8:0]              xSprite,
    input  logic [9:0]              ySprite,
    input  logic [3:0]              spriteId,
    output logic [4+2*SPR_BITS-1:0] romAddress,
    input  logic [15:0]             romData,
    output logic [7:0]              pixelXOut,
    output logic [8:0]              pixelYOut,
    output logic [15:0]             pixelData,
    output logic                    pixelWrite,
    input  logic                    pixelReady,
    output logic                    busy,
    output logic                    frameDone
);

    // Pixel handshake: a pixel is transferred in a cycle where pixelWrite and
    // pixelReady are both high; while pixelWrite is high and pixelReady is low,
    // coordinates and data are held unchanged.

    typedef enum logic [2:0] {IDLE, ERASE, FETCH, WAIT_ROM, DRAW, DONE} state_t;

    localparam logic signed [10:0] XLIM = 11'(LCD_W);
    localparam logic signed [10:0] YLIM = 11'(LCD_H);
    localparam logic [SPR_BITS-1:0] CMAX = '1;

    state_t state, state_nx;

    logic [8:0]          newX, oldX;
    logic [9:0]          newY, oldY;
    logic [3:0]          newId;
    logic                oldValid;
    logic [SPR_BITS-1:0] row, col;
    logic [7:0]          pxX;
    logic [8:0]          pxY;
    logic [15:0]         pxData;

    logic signed [10:0] eraseX, eraseY, drawX, drawY;
    logic               eraseVis, drawVis, last, advance, texSkip;

    function automatic logic onScreen(input logic signed [10:0] x, input logic signed [10:0] y);
        return (x >= 11'sd0) && (x < XLIM) && (y >= 11'sd0) && (y < YLIM);
    endfunction

    // Sprite offsets are unsigned; the box origin is sign-extended to 11 bits.
    assign eraseX = $signed({{2{oldX[8]}}, oldX}) + $signed({{(11-SPR_BITS){1'b0}}, col});
    assign eraseY = $signed({oldY[9], oldY})      + $signed({{(11-SPR_BITS){1'b0}}, row});
    assign drawX  = $signed({{2{newX[8]}}, newX}) + $signed({{(11-SPR_BITS){1'b0}}, col});
    assign drawY  = $signed({newY[9], newY})      + $signed({{(11-SPR_BITS){1'b0}}, row});

    assign eraseVis = onScreen(eraseX, eraseY);
    assign drawVis  = onScreen(drawX, drawY);
    assign last     = (row == CMAX) && (col == CMAX);
    assign texSkip  = (romData == TRANSPARENT) || !drawVis;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (frameStart) state_nx = oldValid ? ERASE : FETCH;
            end
            ERASE: begin
                if (!eraseVis || pixelReady) begin
                    advance = 1'b1;
                    if (last) state_nx = FETCH;
                end
            end
            FETCH: state_nx = WAIT_ROM;
            WAIT_ROM: begin
                if (texSkip) begin
                    advance  = 1'b1;
                    state_nx = last ? DONE : FETCH;
                end else begin
                    state_nx = DRAW;
                end
            end
            DRAW: begin
                if (pixelReady) begin
                    advance  = 1'b1;
                    state_nx = last ? DONE : FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The raster counter wraps to zero after the last pixel, which also
    // clears it for the following phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            newX     <= '0;
            newY     <= '0;
            newId    <= '0;
            oldX     <= '0;
            oldY     <= '0;
            oldValid <= 1'b0;
            row      <= '0;
            col      <= '0;
            pxX      <= '0;
            pxY      <= '0;
            pxData   <= '0;
        end else begin
            if (state == IDLE && frameStart) begin
                newX  <= xSprite;
                newY  <= ySprite;
                newId <= spriteId;
                row   <= '0;
                col   <= '0;
            end else if (advance) begin
                {row, col} <= {row, col} + 1'b1;
            end
            if (state == WAIT_ROM && !texSkip) begin
                pxX    <= drawX[7:0];
                pxY    <= drawY[8:0];
                pxData <= romData;
            end
            if (state == DONE) begin
                oldX     <= newX;
                oldY     <= newY;
                oldValid <= 1'b1;
            end
        end
    end

    assign romAddress = {newId, row, col};
    assign pixelWrite = ((state == ERASE) && eraseVis) || (state == DRAW);
    assign pixelXOut  = (state == ERASE) ? eraseX[7:0] : pxX;
    assign pixelYOut  = (state == ERASE) ? eraseY[8:0] : pxY;
    assign pixelData  = (state == ERASE) ? BG_COLOUR   : pxData;
    assign busy       = (state != IDLE);
    assign frameDone  = (state == DONE);

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: a frame model queues expected pixel writes,
// a negedge monitor pops and compares every accepted write.
module tb_sprite_renderer;

    localparam int W = 33;

    logic        clock = 1'b0;
    logic        reset;
    logic        frameStart;
    logic [8:0]  xSprite;
    logic [9:0]  ySprite;
    logic [3:0]  spriteId;
    logic [13:0] romAddress;
    logic [15:0] romData = 16'h0000;
    logic [7:0]  pixelXOut;
    logic [8:0]  pixelYOut;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        busy;
    logic        frameDone;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int write_cnt = 0;
    int done_cnt  = 0;
    int rom_mode  = 0;
    int ready_mode = 0;
    int cyc = 0;
    int m_old_x, m_old_y;
    bit m_old_valid = 0;
    bit pend = 0;
    logic [W-1:0] pend_val;

    sprite_renderer dut (
        .clock(clock), .reset(reset), .frameStart(frameStart),
        .xSprite(xSprite), .ySprite(ySprite), .spriteId(spriteId),
        .romAddress(romAddress), .romData(romData),
        .pixelXOut(pixelXOut), .pixelYOut(pixelYOut), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .busy(busy), .frameDone(frameDone)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] texel(input int mode, input int id, input int r, input int c);
        logic [3:0] i4;
        logic [4:0] r5, c5;
        i4 = id[3:0];
        r5 = r[4:0];
        c5 = c[4:0];
        case (mode)
            1:       return {2'b00, i4, r5, c5};
            2:       return (c % 2 == 0) ? 16'hF81F : 16'h07E0;
            default: return 16'h07E0;
        endcase
    endfunction

    // Registered sprite ROM: data follows the address by one cycle.
    always @(posedge clock)
        romData <= texel(rom_mode, int'(romAddress[13:10]), int'(romAddress[9:5]), int'(romAddress[4:0]));

    always @(posedge clock) begin
        #1;
        cyc++;
        pixelReady = (ready_mode == 1) ? (cyc % 4 == 0) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic bit vis(input int x, input int y);
        return (x >= 0) && (x < 240) && (y >= 0) && (y < 320);
    endfunction

    task automatic push_px(input int x, input int y, input logic [15:0] d);
        logic [7:0] tx;
        logic [8:0] ty;
        tx = x[7:0];
        ty = y[8:0];
        exp_q.push_back({tx, ty, d});
    endtask

    task automatic push_frame(input int x, input int y, input int id, input int mode);
        if (m_old_valid)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                    if (vis(m_old_x + c, m_old_y + r)) push_px(m_old_x + c, m_old_y + r, 16'hFFFF);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if (texel(mode, id, r, c) != 16'hF81F && vis(x + c, y + r))
                    push_px(x + c, y + r, texel(mode, id, r, c));
        m_old_x = x;
        m_old_y = y;
        m_old_valid = 1;
    endtask

    // Monitor: every accepted write is compared against the queue head; a
    // stalled write must be presented unchanged on the next cycle.
    always @(negedge clock) begin
        if (!reset) begin
            logic [W-1:0] got;
            got = {pixelXOut, pixelYOut, pixelData};
            if (pend) check("hold_stable", {pixelWrite, got}, {1'b1, pend_val});
            pend = pixelWrite && !pixelReady;
            pend_val = got;
            if (frameDone) done_cnt++;
            if (pixelWrite && pixelReady) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d d=%h, expected none", pixelXOut, pixelYOut, pixelData);
                end else begin
                    check("pixel", got, exp_q.pop_front());
                end
            end
        end else begin
            pend = 0;
        end
    end

    task automatic run_frame(input int x, input int y, input int id, input int mode,
                             input int exp_cnt, input bit poke);
        bit ok;
        push_frame(x, y, id, mode);
        rom_mode  = mode;
        write_cnt = 0;
        done_cnt  = 0;
        xSprite  = x[8:0];
        ySprite  = y[9:0];
        spriteId = id[3:0];
        frameStart = 1'b1;
        @(posedge clock); #1;
        frameStart = 1'b0;
        check("busy_start", busy, 1);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clock); #1;
            if (poke && i == 20) begin
                frameStart = 1'b1;
                xSprite = 9'd0;
                ySprite = 10'd0;
                spriteId = 4'd15;
            end
            if (poke && i == 21) frameStart = 1'b0;
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL frame_timeout: got no frameDone, expected one within 20000 cycles");
        end
        @(posedge clock); #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("write_count", write_cnt, exp_cnt);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        frameStart = 1'b0;
        xSprite = '0;
        ySprite = '0;
        spriteId = '0;
        pixelReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_write", pixelWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frameDone, 0);
        check("rst_addr", romAddress, 0);
        check("rst_px", {pixelXOut, pixelYOut, pixelData}, 0);

        run_frame(95, 20, 0, 0, 1024, 0);
        run_frame(100, 20, 1, 1, 2048, 1);
        run_frame(-10, 300, 2, 1, 1464, 0);
        run_frame(50, 50, 3, 2, 952, 0);
        ready_mode = 1;
        run_frame(10, 10, 4, 1, 2048, 0);
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        // Abort a frame mid-draw with reset.
        push_frame(30, 30, 5, 1);
        rom_mode = 1;
        write_cnt = 0;
        xSprite = 9'd30;
        ySprite = 10'd30;
        spriteId = 4'd5;
        frameStart = 1'b1;
        @(posedge clock); #1;
        frameStart = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (write_cnt >= 1100 && pixelWrite) break;
            @(posedge clock); #1;
        end
        check("draw_reached", (write_cnt >= 1100) && pixelWrite, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_write", pixelWrite, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        m_old_valid = 0;
        run_frame(200, 0, 6, 0, 1024, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
